// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with push/pop/full/empty/level
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so a push while full still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a FWFT byte FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115_200,
  parameter int DEPTH  = 8
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         rx,
  output logic [UART_DATA_W-1:0]       data,
  output logic                         valid,
  input  logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         frame_err,
  output logic                         overrun
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(DIV - 1);

  rx_state_t              state;
  logic [1:0]             sync;
  logic [1:0]             fill;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic                   stop_sample;
  logic                   push;
  logic                   pop_ok;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign rx_s        = sync[1];
  assign stop_sample = (state == STOP) && (cnt == FULL_LAST);
  assign push        = stop_sample && rx_s;
  assign valid       = !fifo_empty;
  assign pop_ok      = valid && ready;

  // fill tracks when rx_s carries real pin samples rather than reset values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync <= 2'b11;
      fill <= 2'b00;
    end else begin
      sync <= {sync[0], rx};
      fill <= {fill[0], 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      armed     <= 1'b0;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_prev   <= rx_s;
      cnt       <= cnt + 1'b1;
      // A line held low through reset must go high before a start can count.
      if (fill[1] && rx_s) armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && rx_prev && !rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (!rx_s) begin
              cnt     <= '0;
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[UART_DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            frame_err <= !rx_s;
            overrun   <= rx_s && fifo_full && !pop_ok;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .W     (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_data (shift),
    .pop       (ready),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo at default parameters
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DIV    = 25_000_000 / 115_200;
  localparam int STOP_N = 2 + 9 * DIV + DIV / 2;
  localparam int DEPTH  = 8;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic [3:0] level;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int fe_cycles = 0;
  int ov_cycles = 0;
  logic [7:0] sb [$];

  uart_rx_fifo dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .level     (level),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (frame_err) fe_cycles++;
    if (overrun) ov_cycles++;
    if (frame_err || overrun) begin
      total++;
      if (frame_err && overrun) begin
        bad++;
        $display("FAIL err_exclusive: frame_err=%b overrun=%b, required not both", frame_err, overrun);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // mode 0: plain, 1: check push latency, 2: pulse ready during the stop-sample cycle
  task automatic send_frame(input logic [7:0] b, input bit stop, input int mode);
    logic [9:0] bits;
    int n;
    logic [7:0] head;
    bits = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < DIV; j++) begin
        tick();
        n++;
        if (mode == 1 && n == STOP_N) begin
          total++;
          if (valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: valid=%b at cycle %0d, required 0", valid, n);
          end
        end
        if (mode == 1 && n == STOP_N + 1) begin
          total++;
          if (valid !== 1'b1 || data !== b) begin
            bad++;
            $display("FAIL latency_valid: valid=%b data=%h at cycle %0d, required 1/%h", valid, data, n, b);
          end
        end
        if (mode == 2 && n == STOP_N) begin
          head = (sb.size() > 0) ? sb.pop_front() : 8'h00;
          total++;
          if (data !== head) begin
            bad++;
            $display("FAIL pop_at_stop: data=%h, required %h", data, head);
          end
          ready = 1'b1;
        end
        if (mode == 2 && n == STOP_N + 1) ready = 1'b0;
      end
    end
    rx = 1'b1;
    if (stop && (mode == 2 || sb.size() < DEPTH)) sb.push_back(b);
  endtask

  task automatic drain();
    int guard;
    logic [7:0] exp;
    ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 64) begin
      exp = sb.pop_front();
      total++;
      if (valid !== 1'b1 || data !== exp) begin
        bad++;
        $display("FAIL drain: valid=%b data=%h, required 1/%h", valid, data, exp);
      end
      tick();
      guard++;
    end
    ready = 1'b0;
    total++;
    if (valid !== 1'b0 || level !== 4'd0) begin
      bad++;
      $display("FAIL drain_empty: valid=%b level=%0d, required 0/0", valid, level);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    rx = 1'b1;
    ready = 1'b0;
    idle(3);
    total++;
    if (valid !== 1'b0 || level !== 4'd0 || data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: valid=%b level=%0d data=%h fe=%b ov=%b, required all 0", valid, level, data, frame_err, overrun);
    end
    RST_N = 1'b1;
    idle(10);
  endtask

  task automatic test_single();
    int fe0, ov0;
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    send_frame(8'h55, 1'b1, 1);
    idle(5);
    total++;
    if (level !== 4'd1 || fe_cycles != fe0 || ov_cycles != ov0) begin
      bad++;
      $display("FAIL single: level=%0d fe=%0d ov=%0d, required 1/0/0", level, fe_cycles - fe0, ov_cycles - ov0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 0);
    idle(2);
    total++;
    if (level !== 4'd3) begin
      bad++;
      $display("FAIL b2b_level: level=%0d, required 3", level);
    end
    drain();
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0, 0);
    idle(20);
    total++;
    if (fe_cycles - fe0 != 1 || level !== 4'd0) begin
      bad++;
      $display("FAIL frame_err: pulses=%0d level=%0d, required 1/0", fe_cycles - fe0, level);
    end
    send_frame(8'h81, 1'b1, 0);
    idle(2);
    total++;
    if (level !== 4'd1) begin
      bad++;
      $display("FAIL after_frame_err: level=%0d, required 1", level);
    end
    drain();
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cycles;
    ov0 = ov_cycles;
    rx = 1'b0;
    for (int n = 1; n <= 2 + DIV / 2 + 1; n++) begin
      tick();
      if (n == 50) rx = 1'b1;
      if (n == 2 + DIV / 2) begin
        total++;
        if (dut.state !== START) begin
          bad++;
          $display("FAIL glitch_start: state=%0d at cycle %0d, required START", dut.state, n);
        end
      end
    end
    total++;
    if (dut.state !== IDLE) begin
      bad++;
      $display("FAIL glitch_idle: state=%0d, required IDLE", dut.state);
    end
    idle(3 * DIV);
    total++;
    if (level !== 4'd0 || fe_cycles != fe0 || ov_cycles != ov0) begin
      bad++;
      $display("FAIL glitch_quiet: level=%0d fe=%0d ov=%0d, required 0/0/0", level, fe_cycles - fe0, ov_cycles - ov0);
    end
  endtask

  task automatic test_overrun();
    int ov0;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
    idle(2);
    total++;
    if (level !== 4'd8) begin
      bad++;
      $display("FAIL fill_level: level=%0d, required 8", level);
    end
    ov0 = ov_cycles;
    send_frame(8'hEE, 1'b1, 0);
    idle(5);
    total++;
    if (ov_cycles - ov0 != 1 || level !== 4'd8 || valid !== 1'b1 || data !== sb[0]) begin
      bad++;
      $display("FAIL overrun: pulses=%0d level=%0d head=%h, required 1/8/%h", ov_cycles - ov0, level, data, sb[0]);
    end
    send_frame(8'h77, 1'b1, 2);
    idle(5);
    total++;
    if (ov_cycles - ov0 != 1 || level !== 4'd8) begin
      bad++;
      $display("FAIL push_pop_full: pulses=%0d level=%0d, required 1/8", ov_cycles - ov0, level);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [7:0] part;
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h02, 1'b1, 0);
    send_frame(8'h03, 1'b1, 0);
    part = 8'hF0;
    rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      idle(DIV);
    end
    rx = part[4];
    idle(DIV / 2);
    rx = 1'b0;
    RST_N = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || level !== 4'd0 || data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b level=%0d data=%h fe=%b ov=%b, required all 0", valid, level, data, frame_err, overrun);
    end
    sb.delete();
    idle(5);
    RST_N = 1'b1;
    idle(3 * DIV);
    total++;
    if (dut.state !== IDLE || level !== 4'd0) begin
      bad++;
      $display("FAIL low_at_release: state=%0d level=%0d, required IDLE/0", dut.state, level);
    end
    rx = 1'b1;
    idle(20);
    send_frame(8'h12, 1'b1, 0);
    idle(2);
    total++;
    if (level !== 4'd1) begin
      bad++;
      $display("FAIL after_reset_level: level=%0d, required 1", level);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
